h264dc_hadamard_n: RTL and testbench
====================================

// Module: h264dc_hadamard_n
// PURPOSE
//  Parametrised DC Hadamard transform: 2x2 chroma DC (4 coeffs) or 4x4 Intra16x16 luma DC (16 coeffs), mode chosen per block.
//  Successor to the fixed 2x2 DC transform. Sits between the core transform DC collector and the quantiser.
//  Serial in, serial out, one coefficient per cycle, with ready/valid handshakes on both sides.
// PARAMETERS
//  IN_W   16  signed width of XXIN
//  OUT_W  16  signed width of YYOUT
//  ACC_W  IN_W+4  internal accumulator width; 4x4 growth is 4 bits, so no internal overflow is possible
// PORTS
//  CLK     in   1      clock, rising-edge only
//  RESET   in   1      synchronous, active-high reset
//  MODEIN  in   1      0 = 2x2, 1 = 4x4; sampled with the first accepted coeff of a block
//  READYI  out  1      block can accept XXIN this cycle
//  ENABLE  in   1      XXIN is valid; transfer occurs when ENABLE & READYI
//  XXIN    in   IN_W   signed coeff, raster order (row 0 col 0 first)
//  VALID   out  1      YYOUT is valid; transfer occurs when VALID & READYO
//  YYOUT   out  OUT_W  signed result, raster order
//  LASTO   out  1      with VALID, marks final coeff of block (idx 3 or 15)
//  READYO  in   1      downstream can accept YYOUT
// BEHAVIOUR
//  Reset values: READYI=0, VALID=0, LASTO=0, YYOUT=0; state=LOAD, counters=0. READYI=1 first cycle after RESET low.
//  FSM LOAD -> CALC -> OUT -> LOAD.
//  - LOAD: READYI=1. Each ENABLE&READYI writes XXIN to buf[idx], idx++. MODEIN latched at idx==0.
//    Accepting idx==N-1 (N=4|16) goes to CALC. ENABLE while READYI=0 is ignored, not queued.
//  - CALC: READYI=0.
//    2x2: 1 cycle; a..d = c00,c01,c10,c11:
//      f00=a+b+c+d  f01=a-b+c-d  f10=a+b-c-d  f11=a-b-c+d  (no scaling)
//    4x4: 4 cycles row pass (one row/cycle through 4-pt Hadamard H=[1 1 1 1;1 1 -1 -1;1 -1 -1 1;1 -1 1 -1]),
//      then 4 cycles column pass; final Y=(s+1)>>>1 (arithmetic shift).
//  - OUT: VALID=1, YYOUT=res[odx]. On VALID&READYO, odx++. READYO=0 holds YYOUT/LASTO stable.
//    Handshake of odx==N-1 returns to LOAD; READYI=1 the next cycle (no overlap of blocks).
//  Latency: last input accepted at t -> first VALID at t+2 (2x2) or t+9 (4x4); min block period N+1+calc+N.
//  Width: all arithmetic in ACC_W signed; output reduction per CONFIGURATION.
//  RESET mid-block (any state) discards partial input/results; behaviour as at power-up reset.
//  MODEIN changes mid-block are ignored.
// CONFIGURATION
//  H264DC_SAT_EN defined: result clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  H264DC_SAT_EN undefined: result truncated to low OUT_W bits (two's-complement wrap).
// STRUCTURE
//  Package h264dc_pkg:
//   - typedef dc_mode_e {DC_2X2, DC_4X4}
//   - typedef dc_state_e {ST_LOAD, ST_CALC, ST_OUT}
//   - localparams N_2X2=4, N_4X4=16
//   - function sat_or_trunc()
//  Sub-module h264dc_butterfly4: combinational 4-point Hadamard, ACC_W in/out.
//   Shared by row and column passes; the 2x2 path uses its own adders.
//  Buffer: 16 x ACC_W register array, reused in place for input, intermediate and result.
// TESTING
//  1 2x2 in 1,2,3,4 -> out 10,-2,-4,0; LASTO on 4th; first VALID 2 cycles after last input.
//  2 4x4 all 16 inputs =1 -> out 8 then fifteen 0; first VALID 9 cycles after last input.
//  3 4x4 X00=100, rest 0 -> all 16 outputs 50.
//  4 Backpressure: READYO=0 for 3 cycles mid-output -> YYOUT held; no loss/duplication; READYI=0 until block done.
//  5 RESET after 2 of 4 2x2 inputs, then 2x2 block 5,5,5,5 -> 20,0,0,0 (no stale data).
//  6 IN_W=OUT_W=16, 2x2 all 32767 -> YYOUT[0]=32767 with H264DC_SAT_EN, -4 (0xFFFC) without.

Source files
------------

// File: rtl/h264dc_pkg.sv
// Shared types, block sizes and output width reduction for the DC Hadamard transform.
// Build option: H264DC_SAT_EN selects saturation instead of two's-complement wrap.
package h264dc_pkg;

  typedef enum logic {
    DC_2X2 = 1'b0,
    DC_4X4 = 1'b1
  } dc_mode_e;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CALC,
    ST_OUT
  } dc_state_e;

  localparam int unsigned N_2X2 = 4;
  localparam int unsigned N_4X4 = 16;

  // Reduce a sign-extended accumulator value towards out_w bits; the caller keeps the low bits.
  function automatic logic signed [63:0] sat_or_trunc(input logic signed [63:0] v,
                                                      input int unsigned out_w);
`ifdef H264DC_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
`else
    logic signed [63:0] mask;
    mask = (64'sd1 <<< out_w) - 64'sd1;
    return v & mask;
`endif
  endfunction

endpackage

// File: rtl/h264dc_butterfly4.sv
// Combinational 4-point Hadamard butterfly, rows of H = [1 1 1 1; 1 1 -1 -1; 1 -1 -1 1; 1 -1 1 -1].
module h264dc_butterfly4 #(
  parameter int unsigned ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  input  logic signed [ACC_W-1:0] i_c,
  input  logic signed [ACC_W-1:0] i_d,
  output logic signed [ACC_W-1:0] o_y0,
  output logic signed [ACC_W-1:0] o_y1,
  output logic signed [ACC_W-1:0] o_y2,
  output logic signed [ACC_W-1:0] o_y3
);

  logic signed [ACC_W-1:0] w_s_ab;
  logic signed [ACC_W-1:0] w_d_ab;
  logic signed [ACC_W-1:0] w_s_cd;
  logic signed [ACC_W-1:0] w_d_cd;

  // Two-stage butterfly: pair sums/differences, then combine.
  always_comb begin
    w_s_ab = i_a + i_b;
    w_d_ab = i_a - i_b;
    w_s_cd = i_c + i_d;
    w_d_cd = i_c - i_d;
    o_y0   = w_s_ab + w_s_cd;
    o_y1   = w_s_ab - w_s_cd;
    o_y2   = w_d_ab - w_d_cd;
    o_y3   = w_d_ab + w_d_cd;
  end

endmodule

// File: rtl/h264dc_hadamard_n.sv
// Serial-in/serial-out DC Hadamard transform, 2x2 chroma or 4x4 luma, chosen per block.
// Build option: H264DC_SAT_EN clamps results to OUT_W, otherwise results wrap.
module h264dc_hadamard_n
  import h264dc_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned ACC_W = IN_W + 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MODEIN,
  output logic                    READYI,
  input  logic                    ENABLE,
  input  logic signed [IN_W-1:0]  XXIN,
  output logic                    VALID,
  output logic signed [OUT_W-1:0] YYOUT,
  output logic                    LASTO,
  input  logic                    READYO
);

  localparam logic signed [ACC_W-1:0] ONE = 1;

  dc_state_e               r_state;
  dc_state_e               w_state_d;
  dc_mode_e                r_mode;
  dc_mode_e                w_mode_cur;
  logic [3:0]              r_idx;
  logic [3:0]              r_odx;
  logic [2:0]              r_cnt;
  logic                    r_readyi;
  logic signed [ACC_W-1:0] r_buf [16];

  logic                    w_acc_in;
  logic                    w_acc_out;
  logic                    w_in_last;
  logic                    w_out_last;
  logic                    w_calc_done;
  logic [1:0]              w_line;
  logic signed [ACC_W-1:0] w_bf_in  [4];
  logic signed [ACC_W-1:0] w_bf_out [4];
  logic signed [ACC_W-1:0] w_sh     [4];
  logic signed [ACC_W-1:0] w_f      [4];

  // Handshake and index decode; the mode of the first coeff is taken from MODEIN directly.
  always_comb begin
    w_mode_cur  = (r_idx == 4'd0) ? dc_mode_e'(MODEIN) : r_mode;
    w_acc_in    = ENABLE & r_readyi;
    w_in_last   = w_acc_in &&
                  (r_idx == ((w_mode_cur == DC_4X4) ? 4'(N_4X4 - 1) : 4'(N_2X2 - 1)));
    w_out_last  = (r_odx == ((r_mode == DC_4X4) ? 4'(N_4X4 - 1) : 4'(N_2X2 - 1)));
    w_calc_done = (r_mode == DC_2X2) || (r_cnt == 3'd7);
    w_acc_out   = (r_state == ST_OUT) & READYO;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_d = r_state;
    VALID     = 1'b0;
    LASTO     = 1'b0;
    YYOUT     = '0;
    unique case (r_state)
      ST_LOAD: begin
        if (w_in_last) w_state_d = ST_CALC;
      end
      ST_CALC: begin
        if (w_calc_done) w_state_d = ST_OUT;
      end
      ST_OUT: begin
        VALID = 1'b1;
        LASTO = w_out_last;
        YYOUT = OUT_W'(sat_or_trunc(64'(r_buf[r_odx]), OUT_W));
        if (w_acc_out && w_out_last) w_state_d = ST_LOAD;
      end
      default: w_state_d = ST_LOAD;
    endcase
  end

  // Butterfly operand select: cycles 0-3 take row r_cnt, cycles 4-7 take column r_cnt-4.
  always_comb begin
    w_line = r_cnt[1:0];
    for (int k = 0; k < 4; k++) begin
      if (!r_cnt[2]) begin
        w_bf_in[k] = r_buf[{w_line, 2'(k)}];
      end else begin
        w_bf_in[k] = r_buf[{2'(k), w_line}];
      end
      w_sh[k] = (w_bf_out[k] + ONE) >>> 1;
    end
  end

  // Dedicated 2x2 adders over c00, c01, c10, c11.
  always_comb begin
    w_f[0] = r_buf[0] + r_buf[1] + r_buf[2] + r_buf[3];
    w_f[1] = r_buf[0] - r_buf[1] + r_buf[2] - r_buf[3];
    w_f[2] = r_buf[0] + r_buf[1] - r_buf[2] - r_buf[3];
    w_f[3] = r_buf[0] - r_buf[1] - r_buf[2] + r_buf[3];
  end

  h264dc_butterfly4 #(
    .ACC_W(ACC_W)
  ) u_bf (
    .i_a (w_bf_in[0]),
    .i_b (w_bf_in[1]),
    .i_c (w_bf_in[2]),
    .i_d (w_bf_in[3]),
    .o_y0(w_bf_out[0]),
    .o_y1(w_bf_out[1]),
    .o_y2(w_bf_out[2]),
    .o_y3(w_bf_out[3])
  );

  // Coefficient buffer, rewritten in place by load, row pass, column pass and 2x2 pass.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (w_acc_in) r_buf[r_idx] <= ACC_W'(XXIN);
        end
        ST_CALC: begin
          if (r_mode == DC_2X2) begin
            for (int k = 0; k < 4; k++) r_buf[k] <= w_f[k];
          end else if (!r_cnt[2]) begin
            for (int k = 0; k < 4; k++) r_buf[{w_line, 2'(k)}] <= w_bf_out[k];
          end else begin
            // Final rounding halves the 4x4 result as each column is written back.
            for (int k = 0; k < 4; k++) r_buf[{2'(k), w_line}] <= w_sh[k];
          end
        end
        default: ;
      endcase
    end
  end

  // Counters, latched mode and registered input ready.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx    <= '0;
      r_odx    <= '0;
      r_cnt    <= '0;
      r_mode   <= DC_2X2;
      r_readyi <= 1'b0;
    end else begin
      r_readyi <= (w_state_d == ST_LOAD);
      unique case (r_state)
        ST_LOAD: begin
          if (w_acc_in) begin
            if (r_idx == 4'd0) r_mode <= dc_mode_e'(MODEIN);
            r_idx <= w_in_last ? 4'd0 : r_idx + 4'd1;
          end
        end
        ST_CALC: begin
          r_cnt <= w_calc_done ? 3'd0 : r_cnt + 3'd1;
        end
        ST_OUT: begin
          if (w_acc_out) r_odx <= w_out_last ? 4'd0 : r_odx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign READYI = r_readyi;

endmodule

// File: tb/tb_h264dc_hadamard_n.sv
// Scoreboard bench for h264dc_hadamard_n: the driver queues expected results, a monitor checks them.
module tb_h264dc_hadamard_n;

  logic               clk;
  logic               RESET;
  logic               MODEIN;
  logic               READYI;
  logic               ENABLE;
  logic signed [15:0] XXIN;
  logic               VALID;
  logic signed [15:0] YYOUT;
  logic               LASTO;
  logic               READYO;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t   q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint t_acc   = 0;
  int     vin  [16];
  int     vexp [16];

  h264dc_hadamard_n #(
    .IN_W (16),
    .OUT_W(16),
    .ACC_W(20)
  ) dut (
    .CLK   (clk),
    .RESET (RESET),
    .MODEIN(MODEIN),
    .READYI(READYI),
    .ENABLE(ENABLE),
    .XXIN  (XXIN),
    .VALID (VALID),
    .YYOUT (YYOUT),
    .LASTO (LASTO),
    .READYO(READYO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented output with the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!RESET && VALID) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_output", int'(YYOUT), 0);
      end else begin
        chk(int'(YYOUT) == q[0].data, "yyout", int'(YYOUT), q[0].data);
        chk(LASTO == q[0].last, "lasto", int'(LASTO), int'(q[0].last));
        chk(READYI == 1'b0, "readyi_busy", int'(READYI), 0);
        if (READYO) void'(q.pop_front());
      end
    end
  end

  task automatic push_coef(input int v, input logic m);
    int guard;
    guard = 0;
    @(negedge clk);
    MODEIN = m;
    XXIN   = 16'(v);
    ENABLE = 1'b1;
    while (!READYI && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      chk(1'b0, "readyi_timeout", int'(READYI), 1);
      $display("FAIL abort: input never accepted");
      $fatal(1, "input stall");
    end
    @(posedge clk);
    t_acc = longint'($time);
  endtask

  // Queue expectations, feed n coeffs, then check latency to the first VALID.
  task automatic issue_block(input logic m, input int n, input int exp_lat);
    int     guard;
    longint tv;
    for (int i = 0; i < n; i++) q.push_back('{data: vexp[i], last: (i == n - 1)});
    for (int i = 0; i < n; i++) push_coef(vin[i], m);
    @(negedge clk);
    ENABLE = 1'b0;
    guard  = 0;
    while (!VALID && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    tv = longint'($time);
    chk(VALID == 1'b1, "valid_timeout", int'(VALID), 1);
    chk(int'((tv - 5 - t_acc) / 10) + 1 == exp_lat, "latency",
        int'((tv - 5 - t_acc) / 10) + 1, exp_lat);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
  endtask

  task automatic fill4(input int a, input int b, input int c, input int d,
                       input int ea, input int eb, input int ec, input int ed);
    vin[0]  = a;  vin[1]  = b;  vin[2]  = c;  vin[3]  = d;
    vexp[0] = ea; vexp[1] = eb; vexp[2] = ec; vexp[3] = ed;
  endtask

  initial begin
    RESET  = 1'b1;
    ENABLE = 1'b0;
    XXIN   = '0;
    MODEIN = 1'b0;
    READYO = 1'b1;
    repeat (3) @(negedge clk);
    chk(READYI == 1'b0, "rst_readyi", int'(READYI), 0);
    chk(VALID == 1'b0, "rst_valid", int'(VALID), 0);
    chk(LASTO == 1'b0, "rst_lasto", int'(LASTO), 0);
    chk(YYOUT == 16'sd0, "rst_yyout", int'(YYOUT), 0);
    RESET = 1'b0;
    @(negedge clk);
    chk(READYI == 1'b1, "readyi_after_rst", int'(READYI), 1);

    // 2x2 basic
    fill4(1, 2, 3, 4, 10, -2, -4, 0);
    issue_block(1'b0, 4, 2);
    drain();

    // 4x4 all ones
    for (int i = 0; i < 16; i++) begin
      vin[i]  = 1;
      vexp[i] = (i == 0) ? 8 : 0;
    end
    issue_block(1'b1, 16, 9);
    drain();

    // 4x4 single DC
    for (int i = 0; i < 16; i++) begin
      vin[i]  = (i == 0) ? 100 : 0;
      vexp[i] = 50;
    end
    issue_block(1'b1, 16, 9);
    drain();

    // 4x4 ramp 0..15
    for (int i = 0; i < 16; i++) begin
      vin[i]  = i;
      vexp[i] = 0;
    end
    vexp[0] = 60;  vexp[1] = -8;  vexp[3] = -4;
    vexp[4] = -32; vexp[12] = -16;
    issue_block(1'b1, 16, 9);
    drain();

    // Backpressure on the second output
    fill4(-3, 7, 0, -8, -4, -2, 12, -18);
    issue_block(1'b0, 4, 2);
    @(posedge clk);
    #1 READYO = 1'b0;
    repeat (3) @(posedge clk);
    #1 READYO = 1'b1;
    drain();

    // Reset in the middle of a block, then a clean block
    push_coef(9, 1'b0);
    push_coef(7, 1'b0);
    @(negedge clk);
    ENABLE = 1'b0;
    RESET  = 1'b1;
    @(negedge clk);
    chk(READYI == 1'b0, "midrst_readyi", int'(READYI), 0);
    chk(VALID == 1'b0, "midrst_valid", int'(VALID), 0);
    RESET = 1'b0;
    fill4(5, 5, 5, 5, 20, 0, 0, 0);
    issue_block(1'b0, 4, 2);
    drain();

    // Full-scale 2x2: saturates or wraps depending on build
`ifdef H264DC_SAT_EN
    fill4(32767, 32767, 32767, 32767, 32767, 0, 0, 0);
`else
    fill4(32767, 32767, 32767, 32767, -4, 0, 0, 0);
`endif
    issue_block(1'b0, 4, 2);
    drain();

    repeat (3) @(negedge clk);
    chk(VALID == 1'b0, "idle_valid", int'(VALID), 0);
    chk(READYI == 1'b1, "idle_readyi", int'(READYI), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
